// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
// -----------------------------------------------------------------------------
// Multi-cycle shift-and-add multiplier controller. It owns the datapath ALU
// ports and forms the low DATA_WIDTH bits of multiplicand * multiplier using
// only the ALU ADD and SLL operations. The core stalls on busy and captures
// product on the done pulse.
//
// Optional feature (macro ALU_MUL_EARLY_EXIT_EN):
//   defined   - STEP also exits when the remaining multiplier bits are all zero
//   undefined - fixed latency, always DATA_WIDTH iterations
//   The product value is identical in both builds.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high
//   start        in   request, sampled only in IDLE
//   multiplicand in   operand A, latched on accepted start
//   multiplier   in   operand B, latched on accepted start
//   alu_result   in   combinational ALU result for the current alu_* drive
//   alu_srca     out  ALU SrcA
//   alu_srcb     out  ALU SrcB
//   alu_op       out  ALU Operation
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse, product valid
//   product      out  registered result, held until overwritten by next run
//   dbg_state    out  current FSM state (encoding of state_t)
//
// Handshake: a request is accepted on a rising edge where start=1 and busy=0.
// While busy=1, start is ignored and not queued. The result is presented with
// done=1 for exactly one cycle; product keeps that value afterwards.
// -----------------------------------------------------------------------------
module alu_mul_sequencer #(
   parameter int                     DATA_WIDTH    = 32,
   parameter int                     OPCODE_LENGTH = 4,
   parameter logic [OPCODE_LENGTH-1:0] OP_ADD      = 4'b0010,
   parameter logic [OPCODE_LENGTH-1:0] OP_SLL      = 4'b0100,
   parameter logic [OPCODE_LENGTH-1:0] OP_IDLE     = 4'b1111
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [DATA_WIDTH-1:0]    multiplicand,
   input  logic [DATA_WIDTH-1:0]    multiplier,
   input  logic [DATA_WIDTH-1:0]    alu_result,
   output logic [DATA_WIDTH-1:0]    alu_srca,
   output logic [DATA_WIDTH-1:0]    alu_srcb,
   output logic [OPCODE_LENGTH-1:0] alu_op,
   output logic                     busy,
   output logic                     done,
   output logic [DATA_WIDTH-1:0]    product,
   output logic [2:0]               dbg_state
);

   localparam int CW = $clog2(DATA_WIDTH) + 1;
   localparam logic [CW-1:0]         COUNT_MAX = CW'(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] ONE       = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_STEP  = 3'd1,
      S_ADD   = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
   logic [DATA_WIDTH-1:0] mplr_q, mplr_d;
   logic [DATA_WIDTH-1:0] product_q, product_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  step_exit;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplr_q    <= '0;
         product_q <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         product_q <= product_d;
         count_q   <= count_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      product_d = product_q;
      count_d   = count_q;
      alu_op    = OP_IDLE;
      alu_srca  = '0;
      alu_srcb  = '0;
      busy      = 1'b1;
      done      = 1'b0;

`ifdef ALU_MUL_EARLY_EXIT_EN
      // No set bits left in the multiplier: further iterations add nothing.
      step_exit = (count_q == COUNT_MAX) || (mplr_q == '0);
`else
      step_exit = (count_q == COUNT_MAX);
`endif

      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               acc_d   = '0;
               mcand_d = multiplicand;
               mplr_d  = multiplier;
               count_d = '0;
               state_d = S_STEP;
            end
         end
         S_STEP: begin
            if (step_exit) begin
               // Loaded on the edge into DONE so it is visible with done=1.
               product_d = acc_q;
               state_d   = S_DONE;
            end else if (mplr_q[0]) begin
               state_d = S_ADD;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_ADD: begin
            alu_op   = OP_ADD;
            alu_srca = acc_q;
            alu_srcb = mcand_q;
            acc_d    = alu_result;
            state_d  = S_SHIFT;
         end
         S_SHIFT: begin
            alu_op   = OP_SLL;
            alu_srca = mcand_q;
            alu_srcb = ONE;
            mcand_d  = alu_result;
            mplr_d   = mplr_q >> 1;
            count_d  = count_q + CW'(1);
            state_d  = S_STEP;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign product   = product_q;
   assign dbg_state = state_q;

endmodule
